// File: rtl/dca_matrix_tile_walker_if.sv
// rtl/dca_matrix_tile_walker_if.sv - tile descriptor stream between the walker and the matrix LSU front end
//
// Purpose: carries one tile descriptor per valid/ready handshake.
// Modports:
//   master - producer (tile walker): drives tile_* descriptor fields and tile_valid, samples tile_ready
//   slave  - consumer (LSU front end): samples descriptor fields, drives tile_ready
// Signals:
//   tile_valid / tile_ready       handshake
//   tile_addr                     byte address of tile element (0,0)
//   tile_num_row_m1/col_m1        valid rows/columns in the tile minus 1
//   tile_row_mask/col_mask        bit i set when i <= *_m1
//   tile_idx_y / tile_idx_x       tile position in the matrix
//   tile_is_first / tile_is_last  walk boundary markers
interface dca_matrix_tile_walker_if #(
  parameter int TILE_NUM_ROW = 8,
  parameter int TILE_NUM_COL = 8,
  parameter int BW_ADDR      = 32,
  parameter int BW_DIM       = 16
) ();
  localparam int W_R = ($clog2(TILE_NUM_ROW) < 1) ? 1 : $clog2(TILE_NUM_ROW);
  localparam int W_C = ($clog2(TILE_NUM_COL) < 1) ? 1 : $clog2(TILE_NUM_COL);

  logic                    tile_valid;
  logic                    tile_ready;
  logic [BW_ADDR-1:0]      tile_addr;
  logic [W_R-1:0]          tile_num_row_m1;
  logic [W_C-1:0]          tile_num_col_m1;
  logic [TILE_NUM_ROW-1:0] tile_row_mask;
  logic [TILE_NUM_COL-1:0] tile_col_mask;
  logic [BW_DIM-1:0]       tile_idx_y;
  logic [BW_DIM-1:0]       tile_idx_x;
  logic                    tile_is_first;
  logic                    tile_is_last;

  modport master (
    output tile_valid, tile_addr, tile_num_row_m1, tile_num_col_m1,
           tile_row_mask, tile_col_mask, tile_idx_y, tile_idx_x,
           tile_is_first, tile_is_last,
    input  tile_ready
  );

  modport slave (
    input  tile_valid, tile_addr, tile_num_row_m1, tile_num_col_m1,
           tile_row_mask, tile_col_mask, tile_idx_y, tile_idx_x,
           tile_is_first, tile_is_last,
    output tile_ready
  );
endinterface

// File: rtl/dca_matrix_tile_walker.sv
// rtl/dca_matrix_tile_walker.sv - walks a memory matrix as TILE_NUM_ROW x TILE_NUM_COL tiles, one descriptor per handshake
//
// Purpose: IDLE -> LOAD -> EMIT walker. LOAD latches the configuration and derives
// tile counts, edge sizes and step sizes; EMIT presents one descriptor per cycle
// under continuous ready, holding it while stalled. Addresses are built by
// repeated addition (outer_base / cur_addr), never by multiplication.
// Optional feature macro: DCA_TILE_WALKER_SERPENTINE_EN (odd outer passes walk the
// inner direction backwards, starting at the far tile).
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start, abort         begin a walk (IDLE only) / terminate immediately
//   cfg_*                matrix base, row stride, dims minus 1, element size, loop order
//   busy, done           walk in progress / one-cycle completion pulse
//   tile_if (master)     descriptor stream to the LSU front end
module dca_matrix_tile_walker #(
  parameter int TILE_NUM_ROW = 8,
  parameter int TILE_NUM_COL = 8,
  parameter int BW_ADDR      = 32,
  parameter int BW_STRIDE    = 20,
  parameter int BW_DIM       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [BW_ADDR-1:0]   cfg_addr,
  input  logic [BW_STRIDE-1:0] cfg_stride,
  input  logic [BW_DIM-1:0]    cfg_num_row_m1,
  input  logic [BW_DIM-1:0]    cfg_num_col_m1,
  input  logic [1:0]           cfg_elem_size_log2,
  input  logic                 cfg_col_first,
  output logic                 busy,
  output logic                 done,
  dca_matrix_tile_walker_if.master tile_if
);
  localparam int LG_R = $clog2(TILE_NUM_ROW);
  localparam int LG_C = $clog2(TILE_NUM_COL);
  localparam int W_R  = (LG_R < 1) ? 1 : LG_R;
  localparam int W_C  = (LG_C < 1) ? 1 : LG_C;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EMIT} state_t;

  state_t             r_state;
  logic               r_col_first;
  logic [BW_DIM-1:0]  r_ny_m1, r_nx_m1;
  logic [W_R-1:0]     r_row_edge;
  logic [W_C-1:0]     r_col_edge;
  logic [BW_ADDR-1:0] r_inner_step, r_outer_step;
  logic [BW_ADDR-1:0] r_outer_base, r_cur_addr;
  logic [BW_DIM-1:0]  r_in_idx, r_out_idx;
  logic               r_valid, r_busy, r_done, r_first;
`ifdef DCA_TILE_WALKER_SERPENTINE_EN
  logic [BW_ADDR-1:0] r_far;  // address of the far tile of the current outer pass
  logic               r_rev;  // current inner pass runs backwards
  logic [BW_ADDR-1:0] w_nxt_far;
  logic               w_nxt_rev;
`endif

  // Values derived from cfg_* while in LOAD
  logic [BW_DIM-1:0]  w_ld_ny_m1, w_ld_nx_m1;
  logic [W_R-1:0]     w_ld_row_edge;
  logic [W_C-1:0]     w_ld_col_edge;
  logic [BW_ADDR-1:0] w_ld_col_step, w_ld_row_step;

  assign w_ld_ny_m1    = cfg_num_row_m1 >> LG_R;
  assign w_ld_nx_m1    = cfg_num_col_m1 >> LG_C;
  assign w_ld_col_step = BW_ADDR'(TILE_NUM_COL) << cfg_elem_size_log2;
  assign w_ld_row_step = BW_ADDR'(cfg_stride) << LG_R;

  generate
    if (LG_R == 0) begin : g_row_one
      assign w_ld_row_edge = '0;
    end else begin : g_row_many
      assign w_ld_row_edge = cfg_num_row_m1[W_R-1:0];
    end
    if (LG_C == 0) begin : g_col_one
      assign w_ld_col_edge = '0;
    end else begin : g_col_many
      assign w_ld_col_edge = cfg_num_col_m1[W_C-1:0];
    end
  endgenerate

  // Inner/outer loop decode
  logic [BW_DIM-1:0]  w_inner_m1, w_outer_m1, w_idx_y, w_idx_x;
  logic               w_at_inner_end, w_is_last, w_hs;
  logic [W_R-1:0]     w_row_m1;
  logic [W_C-1:0]     w_col_m1;
  logic [TILE_NUM_ROW-1:0] w_row_mask;
  logic [TILE_NUM_COL-1:0] w_col_mask;
  logic [BW_ADDR-1:0] w_base_step;

  assign w_inner_m1  = r_col_first ? r_nx_m1 : r_ny_m1;
  assign w_outer_m1  = r_col_first ? r_ny_m1 : r_nx_m1;
  assign w_idx_y     = r_col_first ? r_out_idx : r_in_idx;
  assign w_idx_x     = r_col_first ? r_in_idx  : r_out_idx;
`ifdef DCA_TILE_WALKER_SERPENTINE_EN
  assign w_at_inner_end = r_rev ? (r_in_idx == '0) : (r_in_idx == w_inner_m1);
`else
  assign w_at_inner_end = (r_in_idx == w_inner_m1);
`endif
  assign w_is_last   = w_at_inner_end && (r_out_idx == w_outer_m1);
  assign w_hs        = r_valid && tile_if.tile_ready;
  assign w_base_step = r_outer_base + r_outer_step;

  // Only the last tile row/column is partial
  assign w_row_m1 = (w_idx_y == r_ny_m1) ? r_row_edge : W_R'(TILE_NUM_ROW - 1);
  assign w_col_m1 = (w_idx_x == r_nx_m1) ? r_col_edge : W_C'(TILE_NUM_COL - 1);

  always_comb begin
    w_row_mask = '0;
    for (int i = 0; i < TILE_NUM_ROW; i++) w_row_mask[i] = (W_R'(i) <= w_row_m1);
  end

  always_comb begin
    w_col_mask = '0;
    for (int i = 0; i < TILE_NUM_COL; i++) w_col_mask[i] = (W_C'(i) <= w_col_m1);
  end

  // Position and address of the next tile after a handshake
  logic [BW_DIM-1:0]  w_nxt_in_idx, w_nxt_out_idx;
  logic [BW_ADDR-1:0] w_nxt_base, w_nxt_cur;

  always_comb begin
    w_nxt_in_idx  = r_in_idx;
    w_nxt_out_idx = r_out_idx;
    w_nxt_base    = r_outer_base;
    w_nxt_cur     = r_cur_addr;
`ifdef DCA_TILE_WALKER_SERPENTINE_EN
    w_nxt_far     = r_far;
    w_nxt_rev     = r_rev;
    if (w_at_inner_end) begin
      w_nxt_out_idx = r_out_idx + BW_DIM'(1);
      w_nxt_base    = w_base_step;
      w_nxt_rev     = !r_rev;
      // A forward pass ends on the far tile, so its address seeds the next far tile
      w_nxt_far     = (r_rev ? r_far : r_cur_addr) + r_outer_step;
      if (r_rev) begin
        w_nxt_cur    = w_base_step;
        w_nxt_in_idx = '0;
      end else begin
        w_nxt_cur    = w_nxt_far;
        w_nxt_in_idx = w_inner_m1;
      end
    end else if (r_rev) begin
      w_nxt_in_idx = r_in_idx - BW_DIM'(1);
      w_nxt_cur    = r_cur_addr - r_inner_step;
    end else begin
      w_nxt_in_idx = r_in_idx + BW_DIM'(1);
      w_nxt_cur    = r_cur_addr + r_inner_step;
    end
`else
    if (w_at_inner_end) begin
      w_nxt_out_idx = r_out_idx + BW_DIM'(1);
      w_nxt_base    = w_base_step;
      w_nxt_cur     = w_base_step;
      w_nxt_in_idx  = '0;
    end else begin
      w_nxt_in_idx = r_in_idx + BW_DIM'(1);
      w_nxt_cur    = r_cur_addr + r_inner_step;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_col_first  <= 1'b0;
      r_ny_m1      <= '0;
      r_nx_m1      <= '0;
      r_row_edge   <= '0;
      r_col_edge   <= '0;
      r_inner_step <= '0;
      r_outer_step <= '0;
      r_outer_base <= '0;
      r_cur_addr   <= '0;
      r_in_idx     <= '0;
      r_out_idx    <= '0;
      r_valid      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_first      <= 1'b0;
`ifdef DCA_TILE_WALKER_SERPENTINE_EN
      r_far        <= '0;
      r_rev        <= 1'b0;
`endif
    end else if (abort) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_first <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LOAD;
            r_busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          r_col_first  <= cfg_col_first;
          r_ny_m1      <= w_ld_ny_m1;
          r_nx_m1      <= w_ld_nx_m1;
          r_row_edge   <= w_ld_row_edge;
          r_col_edge   <= w_ld_col_edge;
          r_inner_step <= cfg_col_first ? w_ld_col_step : w_ld_row_step;
          r_outer_step <= cfg_col_first ? w_ld_row_step : w_ld_col_step;
          r_outer_base <= cfg_addr;
          r_cur_addr   <= cfg_addr;
          r_in_idx     <= '0;
          r_out_idx    <= '0;
`ifdef DCA_TILE_WALKER_SERPENTINE_EN
          r_far        <= cfg_addr;
          r_rev        <= 1'b0;
`endif
          r_valid      <= 1'b1;
          r_first      <= 1'b1;
          r_state      <= S_EMIT;
        end
        S_EMIT: begin
          if (w_hs) begin
            r_first <= 1'b0;
            if (w_is_last) begin
              r_state <= S_IDLE;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_in_idx     <= w_nxt_in_idx;
              r_out_idx    <= w_nxt_out_idx;
              r_outer_base <= w_nxt_base;
              r_cur_addr   <= w_nxt_cur;
`ifdef DCA_TILE_WALKER_SERPENTINE_EN
              r_far        <= w_nxt_far;
              r_rev        <= w_nxt_rev;
`endif
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;

  // Descriptor fields read as zero whenever no descriptor is offered
  assign tile_if.tile_valid      = r_valid;
  assign tile_if.tile_addr       = r_valid ? r_cur_addr : '0;
  assign tile_if.tile_num_row_m1 = r_valid ? w_row_m1   : '0;
  assign tile_if.tile_num_col_m1 = r_valid ? w_col_m1   : '0;
  assign tile_if.tile_row_mask   = r_valid ? w_row_mask : '0;
  assign tile_if.tile_col_mask   = r_valid ? w_col_mask : '0;
  assign tile_if.tile_idx_y      = r_valid ? w_idx_y    : '0;
  assign tile_if.tile_idx_x      = r_valid ? w_idx_x    : '0;
  assign tile_if.tile_is_first   = r_valid && r_first;
  assign tile_if.tile_is_last    = r_valid && w_is_last;
endmodule

// File: tb/tb_dca_matrix_tile_walker.sv
// tb/tb_dca_matrix_tile_walker.sv - directed self-checking bench for dca_matrix_tile_walker
module tb_dca_matrix_tile_walker;
  localparam int TR = 8, TC = 8, BA = 32, BS = 20, BD = 16;

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic [BA-1:0] cfg_addr;
  logic [BS-1:0] cfg_stride;
  logic [BD-1:0] cfg_num_row_m1, cfg_num_col_m1;
  logic [1:0]    cfg_elem_size_log2;
  logic          cfg_col_first;
  logic          busy, done;

  dca_matrix_tile_walker_if #(.TILE_NUM_ROW(TR), .TILE_NUM_COL(TC), .BW_ADDR(BA), .BW_DIM(BD)) u_if ();

  dca_matrix_tile_walker #(
    .TILE_NUM_ROW(TR), .TILE_NUM_COL(TC), .BW_ADDR(BA), .BW_STRIDE(BS), .BW_DIM(BD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_addr(cfg_addr), .cfg_stride(cfg_stride),
    .cfg_num_row_m1(cfg_num_row_m1), .cfg_num_col_m1(cfg_num_col_m1),
    .cfg_elem_size_log2(cfg_elem_size_log2), .cfg_col_first(cfg_col_first),
    .busy(busy), .done(done), .tile_if(u_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Descriptors accepted during the latest walk
  logic [63:0] a_addr[8], a_y[8], a_x[8], a_rm1[8], a_cm1[8], a_rmk[8], a_cmk[8], a_fst[8], a_lst[8];
  int n_acc;

  task automatic kick(input logic [31:0] addr, input logic [19:0] stride, input logic [15:0] nr,
                      input logic [15:0] nc, input logic [1:0] es, input logic cf);
    cfg_addr = addr; cfg_stride = stride; cfg_num_row_m1 = nr; cfg_num_col_m1 = nc;
    cfg_elem_size_log2 = es; cfg_col_first = cf;
    start = 1'b1;
  endtask

  // Cycle c is observed at the falling edge after the c-th rising edge following start
  task automatic walk(input bit rnd, output int done_cyc, output int n_done, output int n_stall);
    int  c;
    bit  fin, pv, pr;
    logic [31:0] pa;
    logic [31:0] pyx;
    c = 0; fin = 0; pv = 0; pr = 0; pa = '0; pyx = '0;
    done_cyc = -1; n_done = 0; n_stall = 0; n_acc = 0;
    while (!fin && c < 300) begin
      @(negedge clk);
      c++;
      start = 1'b0;
      if (c == 1) begin
        chk("busy_in_load", busy, 1);
        chk("valid_in_load", u_if.tile_valid, 0);
      end
      if (c == 2) begin
        // configuration changes after LOAD must not affect the walk
        cfg_addr = 32'hDEAD_0000; cfg_stride = 20'h1; cfg_num_row_m1 = 16'h7F;
        cfg_num_col_m1 = 16'h7F; cfg_col_first = ~cfg_col_first;
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 && c >= done_cyc + 2) fin = 1;
      u_if.tile_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (u_if.tile_valid) begin
        if (pv && !pr) begin
          chk("hold_addr", u_if.tile_addr, pa);
          chk("hold_idx", {u_if.tile_idx_y, u_if.tile_idx_x}, pyx);
        end
        if (!u_if.tile_ready) n_stall++;
        else if (n_acc < 8) begin
          a_addr[n_acc] = u_if.tile_addr;
          a_y[n_acc]    = u_if.tile_idx_y;
          a_x[n_acc]    = u_if.tile_idx_x;
          a_rm1[n_acc]  = u_if.tile_num_row_m1;
          a_cm1[n_acc]  = u_if.tile_num_col_m1;
          a_rmk[n_acc]  = u_if.tile_row_mask;
          a_cmk[n_acc]  = u_if.tile_col_mask;
          a_fst[n_acc]  = u_if.tile_is_first;
          a_lst[n_acc]  = u_if.tile_is_last;
          n_acc++;
        end
      end
      pv = u_if.tile_valid; pr = u_if.tile_ready;
      pa = u_if.tile_addr;  pyx = {u_if.tile_idx_y, u_if.tile_idx_x};
    end
    if (!fin) chk("walk_timeout", 0, 1);
  endtask

  logic [31:0] e1_addr[4];
  logic [63:0] e2_addr[4], e2_y[4], e2_x[4], e2_rm1[4], e2_rmk[4], e2_cm1[4], e2_cmk[4];
  int dc, nd, ns;

  initial begin
`ifdef DCA_TILE_WALKER_SERPENTINE_EN
    e1_addr = '{32'h1000, 32'h1020, 32'h1220, 32'h1200};
    e2_addr = '{64'h2000, 64'h2080, 64'h2088, 64'h2008};
    e2_y    = '{0, 1, 1, 0};
    e2_rm1  = '{7, 1, 1, 7};
    e2_rmk  = '{64'hFF, 64'h03, 64'h03, 64'hFF};
`else
    e1_addr = '{32'h1000, 32'h1020, 32'h1200, 32'h1220};
    e2_addr = '{64'h2000, 64'h2080, 64'h2008, 64'h2088};
    e2_y    = '{0, 1, 0, 1};
    e2_rm1  = '{7, 1, 7, 1};
    e2_rmk  = '{64'hFF, 64'h03, 64'hFF, 64'h03};
`endif
    e2_x   = '{0, 0, 1, 1};
    e2_cm1 = '{7, 7, 4, 4};
    e2_cmk = '{64'hFF, 64'hFF, 64'h1F, 64'h1F};

    rst = 1'b1; start = 1'b0; abort = 1'b0; u_if.tile_ready = 1'b0;
    cfg_addr = '0; cfg_stride = '0; cfg_num_row_m1 = '0; cfg_num_col_m1 = '0;
    cfg_elem_size_log2 = '0; cfg_col_first = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", u_if.tile_valid, 0);
    chk("rst_addr", u_if.tile_addr, 0);
    chk("rst_masks", {u_if.tile_row_mask, u_if.tile_col_mask}, 0);
    chk("rst_m1_idx", {u_if.tile_num_row_m1, u_if.tile_num_col_m1, u_if.tile_idx_y, u_if.tile_idx_x}, 0);
    chk("rst_first_last", {u_if.tile_is_first, u_if.tile_is_last}, 0);
    rst = 1'b0;
    @(negedge clk);

    // 16x16, 4-byte elements, stride 64, column-first, ready high
    kick(32'h1000, 20'd64, 16'd15, 16'd15, 2'd2, 1'b1);
    walk(1'b0, dc, nd, ns);
    chk("t1_ntiles", n_acc, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_addr%0d", i), a_addr[i], e1_addr[i]);
      chk($sformatf("t1_masks%0d", i), {a_rmk[i][7:0], a_cmk[i][7:0]}, 16'hFFFF);
      chk($sformatf("t1_fl%0d", i), {a_fst[i][0], a_lst[i][0]}, {i == 0, i == 3});
    end
    chk("t1_done_cyc", dc, 6);
    chk("t1_done_cnt", nd, 1);

    // 10x13, 1-byte elements, stride 16, row-first
    kick(32'h2000, 20'd16, 16'd9, 16'd12, 2'd0, 1'b0);
    walk(1'b0, dc, nd, ns);
    chk("t2_ntiles", n_acc, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_addr%0d", i), a_addr[i], e2_addr[i]);
      chk($sformatf("t2_yx%0d", i), {a_y[i][15:0], a_x[i][15:0]}, {e2_y[i][15:0], e2_x[i][15:0]});
      chk($sformatf("t2_rm1_%0d", i), a_rm1[i], e2_rm1[i]);
      chk($sformatf("t2_rmask%0d", i), a_rmk[i], e2_rmk[i]);
      chk($sformatf("t2_cm1_%0d", i), a_cm1[i], e2_cm1[i]);
      chk($sformatf("t2_cmask%0d", i), a_cmk[i], e2_cmk[i]);
    end
    chk("t2_done_cyc", dc, 6);

    // first case again with random backpressure
    kick(32'h1000, 20'd64, 16'd15, 16'd15, 2'd2, 1'b1);
    walk(1'b1, dc, nd, ns);
    chk("t3_ntiles", n_acc, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t3_addr%0d", i), a_addr[i], e1_addr[i]);
    chk("t3_done_cnt", nd, 1);
    chk("t3_latency", dc, 2 + 4 + ns);

    // 1x1 matrix
    kick(32'h3000, 20'd64, 16'd0, 16'd0, 2'd3, 1'b1);
    walk(1'b0, dc, nd, ns);
    chk("t4_ntiles", n_acc, 1);
    chk("t4_addr", a_addr[0], 32'h3000);
    chk("t4_fl", {a_fst[0][0], a_lst[0][0]}, 2'b11);
    chk("t4_m1", {a_rm1[0][2:0], a_cm1[0][2:0]}, 6'd0);
    chk("t4_masks", {a_rmk[0][7:0], a_cmk[0][7:0]}, 16'h0101);
    chk("t4_done_cyc", dc, 3);
    chk("t4_done_cnt", nd, 1);

    // abort on the second valid descriptor
    kick(32'h1000, 20'd64, 16'd15, 16'd15, 2'd2, 1'b1);
    nd = 0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      u_if.tile_ready = 1'b1;
      if (done) nd++;
    end
    chk("t5_valid_before", u_if.tile_valid, 1);
    chk("t5_addr_before", u_if.tile_addr, 32'h1020);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t5_busy_after", busy, 0);
    chk("t5_valid_after", u_if.tile_valid, 0);
    for (int c = 0; c < 4; c++) begin
      if (done) nd++;
      @(negedge clk);
    end
    chk("t5_no_done", nd, 0);
    kick(32'h1000, 20'd64, 16'd15, 16'd15, 2'd2, 1'b1);
    walk(1'b0, dc, nd, ns);
    chk("t5_restart_n", n_acc, 4);
    chk("t5_restart_addr", a_addr[0], 32'h1000);
    chk("t5_restart_fst", a_fst[0], 1);
    chk("t5_restart_done", dc, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dca_matrix_tile_walker.md
# dca_matrix_tile_walker

Parametrised successor to the DCA matrix block splitter. It walks an arbitrary matrix stored in memory as a sequence of TILE_NUM_ROW x TILE_NUM_COL tiles and emits one tile descriptor per valid/ready handshake to the matrix LSU front end. It generalises the splitter in four ways:
- runtime element size;
- independent tile height and width;
- explicit FSM with backpressure and abort;
- optional serpentine traversal.

## Interface
Parameters:
- TILE_NUM_ROW, 8: tile height in elements; power of two, at least 1.
- TILE_NUM_COL, 8: tile width in elements; power of two, at least 1.
- BW_ADDR, 32: byte address width.
- BW_STRIDE, 20: row stride width in bytes.
- BW_DIM, 16: width of the matrix dimension fields (minus-one encoded).

Ports:
- clk, input, 1: clock. One clock domain.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: begin a walk. Sampled only in IDLE.
- abort, input, 1: terminate the walk.
- cfg_addr, input, BW_ADDR: matrix base byte address.
- cfg_stride, input, BW_STRIDE: bytes between consecutive matrix rows.
- cfg_num_row_m1, input, BW_DIM: matrix rows minus 1.
- cfg_num_col_m1, input, BW_DIM: matrix columns minus 1.
- cfg_elem_size_log2, input, 2: element size is 1, 2, 4 or 8 bytes.
- cfg_col_first, input, 1: 1 means the inner loop walks tile columns; 0 means the inner loop walks tile rows.
- busy, output, 1: high from LOAD until done.
- done, output, 1: one-cycle pulse when a walk completes.
- tile_valid, output, 1: descriptor valid.
- tile_ready, input, 1: consumer accepts the descriptor.
- tile_addr, output, BW_ADDR: byte address of tile element (0,0).
- tile_num_row_m1, output, log2(TILE_NUM_ROW) (minimum 1): valid rows in the tile minus 1.
- tile_num_col_m1, output, log2(TILE_NUM_COL) (minimum 1): valid columns in the tile minus 1.
- tile_row_mask, output, TILE_NUM_ROW: bit i = (i <= tile_num_row_m1).
- tile_col_mask, output, TILE_NUM_COL: bit i = (i <= tile_num_col_m1).
- tile_idx_y, output, BW_DIM: tile row index.
- tile_idx_x, output, BW_DIM: tile column index.
- tile_is_first, output, 1: first descriptor of the walk.
- tile_is_last, output, 1: last descriptor of the walk.

## Operation
- FSM states: IDLE, LOAD, EMIT.
- IDLE -> LOAD on start. In LOAD, all cfg_* inputs are latched; later cfg changes have no effect.
- Tile counts are computed in LOAD:
  - ny_m1 = cfg_num_row_m1 >> log2(TILE_NUM_ROW)
  - nx_m1 = cfg_num_col_m1 >> log2(TILE_NUM_COL)
- Edge tiles: the last tile row uses the low log2(TILE_NUM_ROW) bits of cfg_num_row_m1; interior tiles use TILE_NUM_ROW-1. Columns follow the same rule.
- Step sizes:
  - col_step = TILE_NUM_COL << cfg_elem_size_log2
  - row_step = cfg_stride * TILE_NUM_ROW, computed as a shift.
  - inner_step = col_step if cfg_col_first, else row_step. outer_step is the other one.
- Addressing uses two registers, outer_base and cur_addr; tile_addr = cur_addr.
  - Inner advance: cur_addr += inner_step.
  - At inner end: outer_base += outer_step and cur_addr = new outer_base.
  - No multiplier is used.
- Arithmetic is modulo 2^BW_ADDR; overflow wraps silently. Indices never exceed ny_m1 or nx_m1.
- LOAD -> EMIT after one cycle. EMIT -> IDLE on the last handshake, with a done pulse in the following cycle.
- abort in any state: next state is IDLE, tile_valid=0, busy=0, and no done pulse. abort takes priority over start and over a handshake in the same cycle.
- A 1x1 matrix produces exactly one tile, with tile_is_first = tile_is_last = 1.
- start while busy is ignored.
- rst has priority over everything.

## Timing
- Reset: every output is 0; FSM state is IDLE.
- start sampled at cycle T: LOAD at T+1, busy=1 from T+1, first tile_valid at T+2.
- A handshake is valid & ready in the same cycle. Throughput is one tile per cycle under continuous ready, with no bubbles.
- While valid & !ready, all tile_* outputs are held stable. tile_valid never drops without a handshake, except on abort or rst.
- Last handshake at cycle L: tile_valid=0 and busy=0 at L+1, done=1 at L+1 for exactly one cycle. A new start is accepted at L+1.
- Latency from start to done is 2 + number_of_tiles + stall cycles.

## Configuration
- Macro DCA_TILE_WALKER_SERPENTINE_EN.
  - Defined: the inner direction alternates on every outer step. On odd outer passes the inner index counts down and cur_addr steps by -inner_step. The pass starts at the far tile, whose address is outer_base + inner_m1*inner_step, held as a third register updated incrementally. Tile indices and masks always reflect the true tile position.
  - Undefined: every inner pass starts at index 0 at outer_base. The third register and the reversal logic are absent.

## Test plan
- 16x16 matrix (num_m1=15,15), 4-byte elements, stride 64, addr 0x1000, cfg_col_first=1, ready held high -> 4 tiles at 0x1000, 0x1020, 0x1200, 0x1220; all masks 0xFF; done at T+6.
- 10x13 matrix (9,12), 1-byte elements, stride 16, cfg_col_first=0 -> 4 tiles visited in order (y,x) = (0,0), (1,0), (0,1), (1,1). For y=1 tiles: tile_num_row_m1=1, row_mask=0x03. For x=1 tiles: tile_num_col_m1=4, col_mask=0x1F.
- Random tile_ready with 50% duty on the first case -> descriptors held stable while stalled, same 4 addresses in the same order, exactly one done pulse.
- 1x1 matrix -> a single tile with tile_is_first = tile_is_last = 1, masks 0x01, done at T+3.
- abort asserted at the second tile_valid -> busy=0 and tile_valid=0 next cycle, no done pulse. A fresh start then restarts at cfg_addr.
- With DCA_TILE_WALKER_SERPENTINE_EN, first case -> tile addresses 0x1000, 0x1020, 0x1220, 0x1200.
